mips_regfile_sb: RTL and testbench

- Parametrised register file with a write-pending scoreboard for the pipelined MIPS32 core.
- Lets the pipeline drop the dummy "OR R7,R7,R7" spacer instructions: raises `stall` on read-after-write and write-after-write hazards until the producing instruction writes back.
- Sits between ID (issue/read) and WB (writeback).
- Adds a debug preload port, so benches stop poking register contents hierarchically.

---
 rtl/mips_regfile_sb_pkg.sv | 20 ++
 rtl/mips_regfile_sb_if.sv | 55 +++++
 rtl/mips_regfile_sb_scoreboard.sv | 69 ++++++
 rtl/mips_regfile_sb.sv | 116 +++++++++++
 tb/tb_mips_regfile_sb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS32 register file / write-pending scoreboard.
//   DATA_W_DEF   : default register width
//   NUM_REGS_DEF : default number of architectural registers
//   reg_idx_t    : register index type for the default configuration
//   ZERO_REG     : index of the hardwired-zero register
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// -----------------------------------------------------------------------------
// mips_regfile_sb_if
// Bundles the ID issue/read port, the WB writeback port, the debug preload
// port and the scoreboard status between the pipeline and the register file.
//   master : pipeline side (drives issue/wb/dbg, observes stall/fire/data/count)
//   slave  : register file side
// Signals:
//   issue_valid, issue_rs[NUM_RD*AW], issue_rs_used[NUM_RD], issue_rd,
//   issue_rd_used                         -> instruction presented by ID
//   stall, issue_fire                     <- hazard result
//   rd_data[NUM_RD*DATA_W]                <- combinational source data
//   wb_valid, wb_addr, wb_data            -> writeback
//   dbg_we, dbg_addr, dbg_data            -> debug preload
//   pending_cnt[AW+1]                     <- outstanding write count
// -----------------------------------------------------------------------------
interface mips_regfile_sb_if
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     issue_valid;
    logic [NUM_RD*AW-1:0]     issue_rs;
    logic [NUM_RD-1:0]        issue_rs_used;
    logic [AW-1:0]            issue_rd;
    logic                     issue_rd_used;
    logic                     stall;
    logic                     issue_fire;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wb_valid;
    logic [AW-1:0]            wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     dbg_we;
    logic [AW-1:0]            dbg_addr;
    logic [DATA_W-1:0]        dbg_data;
    logic [AW:0]              pending_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rs_used, issue_rd, issue_rd_used,
        output wb_valid, wb_addr, wb_data,
        output dbg_we, dbg_addr, dbg_data,
        input  stall, issue_fire, rd_data, pending_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rs_used, issue_rd, issue_rd_used,
        input  wb_valid, wb_addr, wb_data,
        input  dbg_we, dbg_addr, dbg_data,
        output stall, issue_fire, rd_data, pending_cnt
    );

endinterface

// File: rtl/mips_regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// mips_scoreboard
// One pending bit per architectural register (register 0 never pends) plus a
// registered popcount of those bits.
// Ports:
//   clk1, rst_n  : pipeline clock, asynchronous active-low reset
//   set_en/idx   : issue of an instruction that will write idx
//   clr_en/idx   : writeback to idx
//   byp_clr      : per-index mask of bits to treat as already clear this cycle
//   pend_eff     : registered pending bits with byp_clr applied (for hazards)
//   pending_cnt  : number of registered pending bits
// -----------------------------------------------------------------------------
module mips_scoreboard
    import mips_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [AW-1:0]       set_idx,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_idx,
    input  logic [NUM_REGS-1:0] byp_clr,
    output logic [NUM_REGS-1:0] pend_eff,
    output logic [AW:0]         pending_cnt
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [AW:0]         cnt_q;
    logic [AW:0]         cnt_d;

    assign pend_d[0] = 1'b0;

    genvar gi;
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
        logic set_hit;
        logic clr_hit;
        assign set_hit = set_en && (set_idx == AW'(gi));
        assign clr_hit = clr_en && (clr_idx == AW'(gi));
        // A set in the same cycle as a clear keeps the bit: the newly issued
        // producer is still outstanding even though an older write landed.
        assign pend_d[gi] = set_hit | (pend_q[gi] & ~clr_hit);
    end

    // Count the next-state vector so the count moves on the same edge as pend.
    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_eff    = pend_q & ~byp_clr;
    assign pending_cnt = cnt_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// -----------------------------------------------------------------------------
// mips_regfile_sb
// Register file with write-pending scoreboard for the pipelined MIPS32 core.
// Stalls ID on read-after-write and write-after-write hazards until the
// producing instruction writes back. Register 0 is hardwired to zero.
// Ports:
//   clk1   : pipeline clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   rf     : mips_regfile_sb_if.slave (issue, read data, writeback, debug
//            preload, stall/fire, pending_cnt)
// Build option:
//   FWD_BYPASS_EN : forward a same-cycle writeback to matching read slots and
//                   treat its pending bit as clear for the hazard check, so a
//                   dependent instruction fires in the writeback cycle.
// -----------------------------------------------------------------------------
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk1,
    input  logic              rst_n,
    mips_regfile_sb_if.slave  rf
);

    // Register 0 has no storage; reads of index 0 are forced to zero below.
    logic [DATA_W-1:0]        regs_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:0]      pend_eff;
    logic [NUM_REGS-1:0]      byp_clr;
    logic [NUM_RD-1:0]        raw;
    logic                     waw;
    logic                     wb_hit;
    logic                     stall_w;
    logic                     fire_w;
    logic                     set_en;
    logic [NUM_RD*DATA_W-1:0] rd_data_w;

    assign wb_hit = rf.wb_valid && (rf.wb_addr != AW'(ZERO_REG));

    // Debug preload is applied first so a writeback to the same index
    // overrides it (last non-blocking assignment wins).
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (rf.dbg_we && (rf.dbg_addr != AW'(ZERO_REG))) begin
                regs_q[rf.dbg_addr] <= rf.dbg_data;
            end
            if (wb_hit) begin
                regs_q[rf.wb_addr] <= rf.wb_data;
            end
        end
    end

    genvar gi;

`ifdef FWD_BYPASS_EN
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_byp
        assign byp_clr[gi] = wb_hit && (rf.wb_addr == AW'(gi));
    end
`else
    assign byp_clr = '0;
`endif

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     rs;
        logic [DATA_W-1:0] stored;

        assign rs = rf.issue_rs[gi*AW +: AW];

        always_comb begin
            stored = '0;
            if (rs != AW'(ZERO_REG)) begin
                stored = regs_q[rs];
            end
        end

`ifdef FWD_BYPASS_EN
        assign rd_data_w[gi*DATA_W +: DATA_W] =
            (wb_hit && (rf.wb_addr == rs)) ? rf.wb_data : stored;
`else
        assign rd_data_w[gi*DATA_W +: DATA_W] = stored;
`endif

        assign raw[gi] = rf.issue_rs_used[gi] && (rs != AW'(ZERO_REG)) && pend_eff[rs];
    end

    assign waw     = rf.issue_rd_used && (rf.issue_rd != AW'(ZERO_REG)) && pend_eff[rf.issue_rd];
    assign stall_w = rf.issue_valid && ((|raw) || waw);
    assign fire_w  = rf.issue_valid && !stall_w;
    assign set_en  = fire_w && rf.issue_rd_used && (rf.issue_rd != AW'(ZERO_REG));

    mips_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .set_en      (set_en),
        .set_idx     (rf.issue_rd),
        .clr_en      (wb_hit),
        .clr_idx     (rf.wb_addr),
        .byp_clr     (byp_clr),
        .pend_eff    (pend_eff),
        .pending_cnt (rf.pending_cnt)
    );

    assign rf.stall      = stall_w;
    assign rf.issue_fire = fire_w;
    assign rf.rd_data    = rd_data_w;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile_sb
// Drives directed and random issue/writeback/debug traffic. For every cycle
// the driver computes the expected stall/fire/read data/pending count from an
// array-based model of the register file and a pending-bit array, and queues
// it; a monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_mips_regfile_sb;
    import mips_pkg::*;

    localparam int DW  = DATA_W_DEF;
    localparam int NR  = NUM_REGS_DEF;
    localparam int NRD = 2;
    localparam int AW  = $clog2(NR);

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    mips_regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

    mips_regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .rf    (bus)
    );

    typedef struct {
        bit          rst;
        bit          iv;
        int unsigned rs0, rs1;
        bit          u0, u1;
        int unsigned rd;
        bit          rdu;
        bit          wbv;
        int unsigned wba;
        logic [31:0] wbd;
        bit          dbg;
        int unsigned dbga;
        logic [31:0] dbgd;
    } stim_t;

    typedef struct {
        int          id;
        bit          stall;
        bit          fire;
        logic [31:0] d0, d1;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vectors     = 0;
    int          miscompares = 0;
    int          n_issued    = 0;

    // Behavioural model state
    logic [31:0] m_reg  [NR];
    bit          m_pend [NR];
    bit          m_last_fire  = 0;
    bit          m_last_stall = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.iv = 0; s.rs0 = 0; s.rs1 = 0; s.u0 = 0; s.u1 = 0;
        s.rd = 0; s.rdu = 0; s.wbv = 0; s.wba = 0; s.wbd = '0;
        s.dbg = 0; s.dbga = 0; s.dbgd = '0;
        return s;
    endfunction

    function automatic stim_t iss(int unsigned rs0, bit u0, int unsigned rs1, bit u1,
                                  int unsigned rd, bit rdu);
        stim_t s = idle();
        s.iv = 1; s.rs0 = rs0; s.u0 = u0; s.rs1 = rs1; s.u1 = u1; s.rd = rd; s.rdu = rdu;
        return s;
    endfunction

    function automatic logic [31:0] rd_model(int unsigned rs, stim_t s);
        if (rs == 0) return 32'h0;
`ifdef FWD_BYPASS_EN
        if (s.wbv && s.wba == rs) return s.wbd;
`endif
        return m_reg[rs];
    endfunction

    // One pipeline cycle: drive inputs just after the rising edge, queue the
    // expected response, then advance the model across the next edge.
    task automatic cyc(input stim_t s);
        exp_t e;
        bit   peff [NR];
        bit   raw, waw;
        int   cnt;
        @(posedge clk1);
        #1;
        rst_n             = !s.rst;
        bus.issue_valid   = s.iv;
        bus.issue_rs      = {AW'(s.rs1), AW'(s.rs0)};
        bus.issue_rs_used = {s.u1, s.u0};
        bus.issue_rd      = AW'(s.rd);
        bus.issue_rd_used = s.rdu;
        bus.wb_valid      = s.wbv;
        bus.wb_addr       = AW'(s.wba);
        bus.wb_data       = s.wbd;
        bus.dbg_we        = s.dbg;
        bus.dbg_addr      = AW'(s.dbga);
        bus.dbg_data      = s.dbgd;

        if (s.rst) begin
            for (int r = 0; r < NR; r++) begin
                m_reg[r]  = '0;
                m_pend[r] = 0;
            end
        end
        for (int r = 0; r < NR; r++) peff[r] = m_pend[r];
`ifdef FWD_BYPASS_EN
        if (s.wbv && s.wba != 0) peff[s.wba] = 0;
`endif
        raw = (s.u0 && s.rs0 != 0 && peff[s.rs0]) || (s.u1 && s.rs1 != 0 && peff[s.rs1]);
        waw = s.rdu && s.rd != 0 && peff[s.rd];
        cnt = 0;
        for (int r = 0; r < NR; r++) cnt += int'(m_pend[r]);

        e.id    = n_issued;
        e.stall = s.iv && (raw || waw);
        e.fire  = s.iv && !e.stall;
        e.d0    = rd_model(s.rs0, s);
        e.d1    = rd_model(s.rs1, s);
        e.cnt   = cnt;
        exp_q.push_back(e);
        n_issued++;
        m_last_fire  = e.fire;
        m_last_stall = e.stall;

        if (!s.rst) begin
            if (s.dbg && s.dbga != 0) m_reg[s.dbga] = s.dbgd;
            if (s.wbv && s.wba != 0) begin
                m_reg[s.wba]  = s.wbd;
                m_pend[s.wba] = 0;
            end
            if (e.fire && s.rdu && s.rd != 0) m_pend[s.rd] = 1;
        end
    endtask

    task automatic chk(input int id, input string name, input logic [31:0] got,
                       input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL txn %0d %s: got %h expected %h", id, name, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
    always @(negedge clk1) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            chk(mon_e.id, "stall", 32'(bus.stall), 32'(mon_e.stall));
            chk(mon_e.id, "issue_fire", 32'(bus.issue_fire), 32'(mon_e.fire));
            chk(mon_e.id, "rd_data0", bus.rd_data[31:0], mon_e.d0);
            chk(mon_e.id, "rd_data1", bus.rd_data[63:32], mon_e.d1);
            chk(mon_e.id, "pending_cnt", 32'(bus.pending_cnt), 32'(mon_e.cnt));
            $display("txn %0d: stall=%0b fire=%0b rd0=%h rd1=%h cnt=%0d",
                     mon_e.id, bus.stall, bus.issue_fire, bus.rd_data[31:0],
                     bus.rd_data[63:32], bus.pending_cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        stim_t prev;
        int    pl[$];

        bus.issue_valid = 0; bus.issue_rs = '0; bus.issue_rs_used = '0;
        bus.issue_rd = '0; bus.issue_rd_used = 0; bus.wb_valid = 0;
        bus.wb_addr = '0; bus.wb_data = '0; bus.dbg_we = 0;
        bus.dbg_addr = '0; bus.dbg_data = '0;

        // Reset state
        s = idle(); s.rst = 1;
        cyc(s); cyc(s);

        // Debug preload reg[k] = k
        for (int k = 1; k < NR; k++) begin
            s = idle(); s.dbg = 1; s.dbga = k; s.dbgd = k;
            cyc(s);
        end
        cyc(iss(3, 1, 5, 1, 0, 0));
        cyc(iss(0, 1, 0, 1, 0, 0));

        // ADDI R1,R0,10 then ADD R4,R1,R2 (RAW on R1)
        cyc(iss(0, 1, 0, 0, 1, 1));
        s = iss(1, 1, 2, 1, 4, 1);
        cyc(s); cyc(s);
        s.wbv = 1; s.wba = 1; s.wbd = 32'd10;
        cyc(s);
        if (!m_last_fire) cyc(iss(1, 1, 2, 1, 4, 1));
        s = idle(); s.wbv = 1; s.wba = 4; s.wbd = 32'h44;
        cyc(s);

        // WAW on R4
        s = iss(0, 0, 0, 0, 4, 1);
        cyc(s); cyc(s);
        s.wbv = 1; s.wba = 4; s.wbd = 32'h4;
        cyc(s);
        if (!m_last_fire) cyc(iss(0, 0, 0, 0, 4, 1));
        s = idle(); cyc(s);
        s.wbv = 1; s.wba = 4; s.wbd = 32'h4;
        cyc(s);

        // Register 0: no pending, writes ignored
        s = iss(0, 1, 0, 1, 0, 1); s.wbv = 1; s.wba = 0; s.wbd = 32'hDEAD;
        cyc(s);
        cyc(iss(0, 1, 0, 1, 0, 1));

        // Reset mid-stall
        cyc(iss(0, 0, 0, 0, 7, 1));
        s = iss(7, 1, 0, 0, 0, 0);
        cyc(s);
        s.rst = 1; cyc(s);
        s.rst = 0; cyc(s);
        s = idle(); s.wbv = 1; s.wba = 7; s.wbd = 32'h55;
        cyc(s);
        cyc(iss(7, 1, 0, 0, 0, 0));

        // Debug and writeback to the same index: writeback wins
        s = idle(); s.dbg = 1; s.dbga = 9; s.dbgd = 32'h11;
        s.wbv = 1; s.wba = 9; s.wbd = 32'h22;
        cyc(s);
        cyc(iss(9, 1, 0, 0, 0, 0));

        // Random traffic; a stalled instruction is held like ID would
        prev = idle();
        repeat (300) begin
            s = idle();
            if (m_last_stall && $urandom_range(0, 4) != 0) begin
                s.iv = 1; s.rs0 = prev.rs0; s.rs1 = prev.rs1; s.u0 = prev.u0;
                s.u1 = prev.u1; s.rd = prev.rd; s.rdu = prev.rdu;
            end else begin
                s.iv  = ($urandom_range(0, 3) != 0);
                s.rs0 = $urandom_range(0, 7); s.u0 = $urandom_range(0, 1);
                s.rs1 = $urandom_range(0, 7); s.u1 = $urandom_range(0, 1);
                s.rd  = $urandom_range(0, 7); s.rdu = $urandom_range(0, 1);
            end
            pl.delete();
            for (int r = 1; r < NR; r++) if (m_pend[r]) pl.push_back(r);
            s.wbv = ($urandom_range(0, 2) != 0);
            if (pl.size() > 0 && $urandom_range(0, 3) != 0)
                s.wba = pl[$urandom_range(0, pl.size() - 1)];
            else
                s.wba = $urandom_range(0, 7);
            s.wbd  = $urandom;
            s.dbg  = ($urandom_range(0, 9) == 0);
            s.dbga = $urandom_range(0, NR - 1);
            s.dbgd = $urandom;
            cyc(s);
            prev = s;
        end

        s = idle();
        cyc(s);
        @(negedge clk1);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
